// File: rtl/lenet_pkg.sv
// ============================================================================
// Module   : lenet_pkg
// Brief    : Shared LeNet constants and the layer-1 read-FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lenet_pkg;

  localparam int DATA_W        = 16;
  localparam int L1_FMAP_SIZE  = 12;
  localparam int L1_FMAP_WORDS = L1_FMAP_SIZE * L1_FMAP_SIZE;
  localparam int L1_CNT_W      = $clog2(L1_FMAP_WORDS);

  localparam logic [1:0] c_rd_idle   = 2'd0;
  localparam logic [1:0] c_rd_fetch  = 2'd1;
  localparam logic [1:0] c_rd_stream = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fmap_bank_ram.sv
// ============================================================================
// Module   : fmap_bank_ram
// Brief    : Simple dual-port RAM, synchronous write, registered 1-clk read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fmap_bank_ram #(
  parameter int DATA_W = lenet_pkg::DATA_W,
  parameter int ADDR_W = lenet_pkg::L1_CNT_W + 1
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  // Addressed as {bank, cnt}, so the array spans the full address space.
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/layer1_fmap_pingpong.sv
// ============================================================================
// Module   : layer1_fmap_pingpong
// Brief    : Ping-pong buffer for the 12x12 pooled map; fills one bank while
//            streaming the other to layer 2 over valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module layer1_fmap_pingpong #(
  parameter int DATA_W    = lenet_pkg::DATA_W,
  parameter int FMAP_SIZE = lenet_pkg::L1_FMAP_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              frame_done,
  output logic              overflow_err
);

  import lenet_pkg::*;

  localparam int c_words  = FMAP_SIZE * FMAP_SIZE;
  localparam int c_cnt_w  = $clog2(c_words);
  localparam int c_addr_w = c_cnt_w + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_words - 1);

  logic [1:0]         r_full;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic [c_cnt_w-1:0] r_wr_cnt;
  logic [c_cnt_w-1:0] r_rd_cnt;
  logic [1:0]         r_state;
  logic               r_dout_valid;
  logic               r_frame_done;
  logic               r_overflow;

  logic               w_wr_en;
  logic               w_wr_last;
  logic               w_hs;
  logic               w_rd_last_hs;
  logic               w_rd_en;
  logic [c_cnt_w-1:0] w_rd_cnt;
  logic [1:0]         w_full_nxt;
  logic [DATA_W-1:0]  w_ram_q;

  assign din_ready    = !r_full[r_wr_bank];
  assign w_wr_en      = din_valid && din_ready;
  assign w_wr_last    = w_wr_en && (r_wr_cnt == c_last);
  assign w_hs         = r_dout_valid && dout_ready;
  assign w_rd_last_hs = w_hs && (r_rd_cnt == c_last);

  // RAM read address: word 0 in FETCH, then prefetch the next word on each
  // handshake so the stream runs at one word per clock.
  always_comb begin
    w_rd_en  = 1'b0;
    w_rd_cnt = '0;
    if (r_state == c_rd_fetch) begin
      w_rd_en = 1'b1;
    end else if ((r_state == c_rd_stream) && w_hs && (r_rd_cnt != c_last)) begin
      w_rd_en  = 1'b1;
      w_rd_cnt = r_rd_cnt + 1'b1;
    end
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_rd_last_hs) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full     <= '0;
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (din_valid && !din_ready) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_en) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= !r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_rd_idle;
      r_rd_bank    <= 1'b0;
      r_rd_cnt     <= '0;
      r_dout_valid <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        c_rd_idle: begin
          if (r_full[r_rd_bank]) begin
            r_state  <= c_rd_fetch;
            r_rd_cnt <= '0;
          end
        end
        c_rd_fetch: begin
          r_state      <= c_rd_stream;
          r_dout_valid <= 1'b1;
        end
        c_rd_stream: begin
          if (w_rd_last_hs) begin
            r_state      <= c_rd_idle;
            r_dout_valid <= 1'b0;
            r_rd_cnt     <= '0;
            r_rd_bank    <= !r_rd_bank;
            r_frame_done <= 1'b1;
          end else if (w_hs) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= c_rd_idle;
          r_dout_valid <= 1'b0;
        end
      endcase
    end
  end

  fmap_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (c_addr_w)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr ({r_wr_bank, r_wr_cnt}),
    .i_wr_data (din),
    .i_rd_en   (w_rd_en),
    .i_rd_addr ({r_rd_bank, w_rd_cnt}),
    .o_rd_data (w_ram_q)
  );

  // Gating on valid makes dout drop to zero asynchronously with reset.
  assign dout         = r_dout_valid ? w_ram_q : '0;
  assign dout_valid   = r_dout_valid;
  assign dout_last    = r_dout_valid && (r_rd_cnt == c_last);
  assign frame_done   = r_frame_done;
  assign overflow_err = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_layer1_fmap_pingpong.sv
// ============================================================================
// Module   : tb_layer1_fmap_pingpong
// Brief    : Self-checking bench for layer1_fmap_pingpong (scoreboard queue).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_layer1_fmap_pingpong;

  import lenet_pkg::*;

  localparam int c_n = L1_FMAP_WORDS;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic              dout_last;
  logic              frame_done;
  logic              overflow_err;

  layer1_fmap_pingpong dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_last    (dout_last),
    .frame_done   (frame_done),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    int base;
    int ready_pct;
    bit extremes;
    int exp_first;
    int exp_last;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[4];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_cyc   = 0;
  int ready_pct = 100;
  int frames_rx = 0;
  int rx_in_frame = 0;
  int rx_first = 0;
  int rx_last  = 0;
  int first_valid_cyc = -1;
  bit prev_stall = 1'b0;
  bit prev_last_hs = 1'b0;
  logic [DATA_W-1:0] prev_dout = '0;
  logic prev_dlast = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic abort(input string name);
    n_checks++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "bench stopped early");
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    dout_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
  end

  // Output monitor: pops the scoreboard on every handshake, checks stall
  // stability, frame_done timing and din_ready recovery after each drain.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      check(frame_done == prev_last_hs, "frame_done", longint'(frame_done), longint'(prev_last_hs));
      if (prev_last_hs)
        check(din_ready == 1'b1, "din_ready_after_drain", longint'(din_ready), 1);
      if (prev_stall)
        check(dout_valid && (dout == prev_dout) && (dout_last == prev_dlast), "stall_hold",
              longint'({dout_valid, dout_last, dout}), longint'({1'b1, prev_dlast, prev_dout}));
      if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_word", longint'($signed(dout)), 0);
        end else begin
          e = exp_q.pop_front();
          check({dout_last, dout} == {e.last, e.data}, "dout",
                longint'({dout_last, dout}), longint'({e.last, e.data}));
        end
        if (rx_in_frame == 0) rx_first = int'($signed(dout));
        rx_last = int'($signed(dout));
        rx_in_frame++;
        if (dout_last) begin
          frames_rx++;
          rx_in_frame = 0;
        end
      end
      prev_stall   = dout_valid && !dout_ready;
      prev_dout    = dout;
      prev_dlast   = dout_last;
      prev_last_hs = dout_valid && dout_ready && dout_last;
    end
  end

  task automatic write_word(input logic [DATA_W-1:0] v, input bit last);
    exp_t e;
    int waited = 0;
    @(negedge clk);
    while (!din_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!din_ready) abort("din_ready_timeout");
    din       = v;
    din_valid = 1'b1;
    e.last = last;
    e.data = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    wr_cyc    = cyc;
  endtask

  task automatic write_frame(input int base, input bit ext, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      logic [DATA_W-1:0] v;
      v = DATA_W'(base + i);
      if (ext && i == 0) v = 16'h8000;
      if (ext && i == c_n - 1) v = 16'h7FFF;
      write_word(v, i == c_n - 1);
    end
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (frames_rx < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (frames_rx < target) abort("frame_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check(dout == '0,        {tag, "_dout"},       longint'(dout), 0);
    check(dout_valid == 0,   {tag, "_dout_valid"}, longint'(dout_valid), 0);
    check(dout_last == 0,    {tag, "_dout_last"},  longint'(dout_last), 0);
    check(frame_done == 0,   {tag, "_frame_done"}, longint'(frame_done), 0);
    check(overflow_err == 0, {tag, "_overflow"},   longint'(overflow_err), 0);
    check(din_ready == 1,    {tag, "_din_ready"},  longint'(din_ready), 1);
  endtask

  initial begin
    #800000;
    abort("global_watchdog");
  end

  initial begin
    int f0;
    int t;

    vecs[0] = '{-72,   100, 1'b0, -72,    71};
    vecs[1] = '{1000,  50,  1'b1, -32768, 32767};
    vecs[2] = '{-5000, 50,  1'b0, -5000,  -4857};
    vecs[3] = '{32700, 100, 1'b1, -32768, 32767};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Single frames: ramp, signed extremes, random backpressure.
    for (int k = 0; k < 4; k++) begin
      f0 = frames_rx;
      ready_pct = vecs[k].ready_pct;
      first_valid_cyc = -1;
      write_frame(vecs[k].base, vecs[k].extremes, c_n);
      wait_frames(f0 + 1);
      check(rx_first == vecs[k].exp_first, "first_word", rx_first, vecs[k].exp_first);
      check(rx_last == vecs[k].exp_last, "last_word", rx_last, vecs[k].exp_last);
      if (k == 0)
        check(first_valid_cyc - wr_cyc == 2, "latency", first_valid_cyc - wr_cyc, 2);
    end

    // Both banks full with the consumer stalled, then a third frame queued.
    ready_pct = 0;
    f0 = frames_rx;
    write_frame(2000, 1'b0, c_n);
    write_frame(-3000, 1'b0, c_n);
    @(negedge clk);
    check(din_ready == 0, "din_ready_both_full", longint'(din_ready), 0);
    repeat (20) @(negedge clk);
    check(din_ready == 0, "din_ready_held_low", longint'(din_ready), 0);
    check(dout_valid == 1, "dout_valid_stalled", longint'(dout_valid), 1);
    ready_pct = 100;
    write_frame(7000, 1'b0, c_n);
    wait_frames(f0 + 3);
    check(rx_first == 7000, "third_frame_first", rx_first, 7000);
    check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

    // Overflow: data offered with no free bank is dropped, flag is sticky.
    ready_pct = 0;
    f0 = frames_rx;
    check(overflow_err == 0, "ovf_initially_clear", longint'(overflow_err), 0);
    write_frame(200, 1'b0, c_n);
    write_frame(-300, 1'b0, c_n);
    @(negedge clk);
    din       = 16'h1234;
    din_valid = 1'b1;
    repeat (5) @(negedge clk);
    din_valid = 1'b0;
    check(overflow_err == 1, "ovf_set", longint'(overflow_err), 1);
    ready_pct = 100;
    wait_frames(f0 + 2);
    check(overflow_err == 1, "ovf_sticky_1", longint'(overflow_err), 1);
    write_frame(-600, 1'b1, c_n);
    wait_frames(f0 + 3);
    check(overflow_err == 1, "ovf_sticky_2", longint'(overflow_err), 1);
    check(rx_first == -32768, "ovf_frame_first", rx_first, -32768);

    // Reset mid-stream with the other bank partly written.
    ready_pct = 0;
    write_frame(500, 1'b0, c_n);
    write_frame(900, 1'b0, 30);
    ready_pct = 100;
    t = 0;
    while (rx_in_frame < 50 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (rx_in_frame < 50) abort("read_word_50_timeout");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    rx_in_frame = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    f0 = frames_rx;
    write_frame(-144, 1'b0, c_n);
    wait_frames(f0 + 1);
    check(rx_first == -144, "post_reset_first", rx_first, -144);
    check(rx_last == -1, "post_reset_last", rx_last, -1);
    repeat (3) @(negedge clk);
    check(exp_q.size() == 0, "final_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
